clock_div_bank: RTL and testbench
=================================

# clock_div_bank

Parametrised bank of programmable clock dividers for the lab clock-generation path, generalising the fixed-ratio divider. Produces NUM_CH divided clocks from one input clock. Each channel's ratio is runtime-reloadable through a valid/ready configuration port. Ratio changes are glitch-free, and all channels can be phase-aligned with a restart pulse. A 32-bit edge counter on one selectable channel replaces the old toggle counter.

## Interface
- NUM_CH, 4: number of divider channels (1..16)
- DIV_W, 8: divisor width in bits
- DEF_DIV, 2: divisor loaded into every channel at reset (must be ≥2 and <2^DIV_W)
- CNT_CH, 0: channel whose rising edges are counted by edge_count
- clk_in  input  1  input clock; all logic on rising edge, except the optional path in Configuration
- rst  input  1  asynchronous, active-high reset
- cfg_valid  input  1  configuration request
- cfg_ready  output  1  configuration accepted when cfg_valid && cfg_ready
- cfg_ch  input  $clog2(NUM_CH)  target channel
- cfg_div  input  DIV_W  new divisor N
- sync_restart  input  1  one-cycle pulse; re-phases all channels
- clk_div  output  NUM_CH  divided clocks, registered
- div_stb  output  NUM_CH  one-cycle pulse coincident with the first high cycle of each clk_div period
- edge_count  output  32  count of rising edges of clk_div[CNT_CH]

## Operation
- Per channel: active divisor N, period counter cnt (0..N-1), pending divisor, and pending flag.
- Waveform for N≥2:
  - clk_div is high while cnt < H = ceil(N/2) and low for the remaining L = floor(N/2) cycles.
  - cnt wraps N-1 → 0.
- N<2 (0 or 1): channel disabled.
  - clk_div=0, div_stb=0, cnt held at 0.
- Config accept (cfg_valid && cfg_ready):
  - Writes pending[cfg_ch] = cfg_div and sets the pending flag.
  - cfg_ch ≥ NUM_CH: the request is accepted and discarded.
- cfg_ready = !pending_flag[cfg_ch]; this is combinational on cfg_ch.
- Pending update applied at the period boundary, i.e. the edge where cnt wraps to 0.
  - At that edge: N takes the pending value, cnt restarts at 0, and the pending flag clears.
  - The first period uses the new N. No partial period and no runt pulse.
- Disabled channel with pending update: applied on the next edge.
- sync_restart:
  - On the next edge, every channel's cnt goes to 0 and any pending divisor is applied.
  - clk_div is then high on the following cycle for all enabled channels simultaneously.
- sync_restart and config accept in the same cycle: the new divisor is applied by that restart edge, and pending stays clear.
- edge_count increments on every div_stb[CNT_CH] and wraps 0xFFFF_FFFF → 0.

## Timing
- Reset values:
  - clk_div = 0, div_stb = 0, edge_count = 0, cnt = 0.
  - N = DEF_DIV for all channels, pending flags clear, cfg_ready = 1.
- First rising clk_in edge after rst deasserts:
  - clk_div[i] = 1 and div_stb[i] = 1 for all channels.
  - edge_count becomes 1 one edge later (registered from div_stb).
- Period exactly N clk_in cycles, steady state.
- Reconfig latency: accept at edge k with cfg_ready low until the boundary edge. The new waveform starts at the first boundary after k: at most N_old cycles, and 1 cycle if disabled.
- sync_restart sampled at edge k: clk_div = 1 and div_stb = 1 at edge k+1.
- rst asserted mid-period: outputs go to reset values immediately (asynchronous). Pending updates are lost.

## Configuration
- CLKDIV_ODD50_EN defined:
  - For odd N≥3, a falling-edge copy of the high term is ANDed with it, giving exactly N/2 cycles high (50% duty).
  - The rising edge of clk_div is unchanged. The falling edge moves half a cycle earlier.
  - div_stb is unchanged.
- Undefined: odd N gives H=(N+1)/2 high and L=(N-1)/2 low, and there is no negedge logic. Even N behaves identically in both builds.

## Structure
- Package clock_div_pkg:
  - Constants DIV_W_MAX=16 and CH_MAX=16.
  - Function half_hi(N) returning ceil(N/2).
  - Typedef div_t for the divisor.
- Sub-module clock_div_chan: one channel (cnt, N, pending, waveform, odd-50% path), instantiated NUM_CH times by generate.
- The top holds the config decode, cfg_ready mux, and edge_count.

## Test plan
- Reset, default N=2, 10 ns clk_in: after rst release all clk_div toggle every 10 ns with 20 ns period; div_stb every 2 cycles; edge_count=5 after 10 cycles.
- cfg ch0 N=4 mid-period: cfg_ready[ch0] low until the wrap; then clk_div[0] is 2 high / 2 low. No runt pulse.
- cfg ch1 N=5, macro undefined: 30 ns high / 20 ns low. Macro defined: 25 ns high / 25 ns low, rising edges identical in both builds.
- cfg ch2 N=1: clk_div[2] stuck 0, no div_stb. Then cfg N=6: clk_div[2] high on the next edge, period 60 ns.
- Channels at N=3,4,7 followed by sync_restart: all clk_div rise on the same edge, exactly one cycle after the pulse. Simultaneous cfg of ch0 to N=8 takes effect on that edge.
- Force edge_count to 0xFFFF_FFFE with CNT_CH at N=2: it reads 0 after two div_stb pulses. Then assert rst mid-high: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the clock divider bank.
// Optional build macro used by this family: CLKDIV_ODD50_EN (50% duty for odd divisors).
package clock_div_pkg;

    localparam int DIV_W_MAX = 16;
    localparam int CH_MAX    = 16;

    // Divisor carried at the widest supported width so helpers work for any DIV_W.
    typedef logic [DIV_W_MAX-1:0] div_t;

    // Number of high cycles in one period: ceil(N/2).
    function automatic div_t half_hi(input div_t n);
        return (n >> 1) + {{(DIV_W_MAX-1){1'b0}}, n[0]};
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: active divisor, period counter, pending reload and waveform.
// Macro CLKDIV_ODD50_EN adds a falling-edge term that trims odd-N high time to N/2.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             i_cfg_acc,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic             i_restart,
    output logic             o_pending,
    output logic             o_clk_div,
    output logic             o_div_stb
);

    logic [DIV_W-1:0] r_n;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_clk;
    logic             r_stb;

    logic             w_apply;
    logic [DIV_W-1:0] w_n_eff;
    logic [DIV_W-1:0] w_cnt_next;
    logic             w_hi_next;
    logic             w_stb_next;

    // A pending divisor may only take over when the next cycle starts a new period.
    assign w_apply = r_pend && (r_cnt == '0);

    // Divisor governing the cycle about to be presented (restart or boundary reload).
    always_comb begin
        w_n_eff = r_n;
        if (i_restart) begin
            if (i_cfg_acc) begin
                w_n_eff = i_cfg_div;
            end else if (r_pend) begin
                w_n_eff = r_pend_div;
            end
        end else if (w_apply) begin
            w_n_eff = r_pend_div;
        end
    end

    // Next waveform value and counter; restart edges and disabled channels output low.
    always_comb begin
        w_cnt_next = '0;
        w_hi_next  = 1'b0;
        w_stb_next = 1'b0;
        if (!i_restart && (w_n_eff >= DIV_W'(2))) begin
            w_hi_next  = div_t'(r_cnt) < half_hi(div_t'(w_n_eff));
            w_stb_next = (r_cnt == '0);
            w_cnt_next = (r_cnt == (w_n_eff - DIV_W'(1))) ? '0 : (r_cnt + DIV_W'(1));
        end
    end

    // Divisor, period counter and registered outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_n   <= DIV_W'(DEF_DIV);
            r_cnt <= '0;
            r_clk <= 1'b0;
            r_stb <= 1'b0;
        end else begin
            r_n   <= w_n_eff;
            r_cnt <= w_cnt_next;
            r_clk <= w_hi_next;
            r_stb <= w_stb_next;
        end
    end

    // Pending reload slot: cleared when consumed by a boundary or a restart.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_div <= '0;
        end else if (i_restart || w_apply) begin
            r_pend     <= 1'b0;
        end else if (i_cfg_acc) begin
            r_pend     <= 1'b1;
            r_pend_div <= i_cfg_div;
        end
    end

`ifdef CLKDIV_ODD50_EN
    logic r_odd;
    logic r_neg;

    // Remember whether the current cycle belongs to an odd divisor of at least 3.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_odd <= 1'b0;
        end else begin
            r_odd <= w_n_eff[0] && (w_n_eff >= DIV_W'(3));
        end
    end

    // Half-cycle look-ahead of the high term; drops mid-cycle before a falling edge.
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            r_neg <= 1'b1;
        end else begin
            r_neg <= w_hi_next;
        end
    end

    assign o_clk_div = r_clk & (~r_odd | r_neg);
`else
    assign o_clk_div = r_clk;
`endif

    assign o_div_stb = r_stb;
    assign o_pending = r_pend;

endmodule

// File: rtl/clock_div_bank.sv
// Bank of NUM_CH programmable clock dividers with config port, restart and edge counter.
// Macro CLKDIV_ODD50_EN selects 50% duty for odd divisors inside each channel.
module clock_div_bank
    import clock_div_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int DIV_W   = 8,
    parameter  int DEF_DIV = 2,
    parameter  int CNT_CH  = 0,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] div_stb,
    output logic [31:0]       edge_count
);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_acc;
    logic [31:0]       r_edge_count;

    // Ready reflects the addressed channel's pending slot; unknown channels always accept.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~w_pending[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            assign w_acc[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

            clock_div_chan #(
                .DIV_W   (DIV_W),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .clk_in    (clk_in),
                .rst       (rst),
                .i_cfg_acc (w_acc[g]),
                .i_cfg_div (cfg_div),
                .i_restart (sync_restart),
                .o_pending (w_pending[g]),
                .o_clk_div (clk_div[g]),
                .o_div_stb (div_stb[g])
            );
        end
    endgenerate

    // Count period starts of the monitored channel, wrapping naturally at 2^32.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_edge_count <= '0;
        end else if (div_stb[CNT_CH]) begin
            r_edge_count <= r_edge_count + 32'd1;
        end
    end

    assign edge_count = r_edge_count;

endmodule

// File: tb/tb_clock_div_bank.sv
// Bench for clock_div_bank: period-arithmetic reference model plus directed literal checks.
// Build with CLKDIV_ODD50_EN defined to also check the mid-cycle odd-divisor waveform.
module tb_clock_div_bank;

    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 2;
    localparam int CNT_CH  = 0;

    logic              clk_in;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              sync_restart;
    logic [NUM_CH-1:0] clk_div;
    logic [NUM_CH-1:0] div_stb;
    logic [31:0]       edge_count;

    int checks;
    int passes;

    clock_div_bank #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV),
        .CNT_CH  (CNT_CH)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .sync_restart (sync_restart),
        .clk_div      (clk_div),
        .div_stb      (div_stb),
        .edge_count   (edge_count)
    );

    // 10 ns input clock.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: each channel tracks the cycle its current period began and
    // derives its phase as (cycle - start) mod N.
    int          cyc;
    int          mN     [NUM_CH];
    int          mStart [NUM_CH];
    int          mPd    [NUM_CH];
    bit          mPend  [NUM_CH];
    bit          mHi    [NUM_CH];
    bit          mStb   [NUM_CH];
    bit          mLast  [NUM_CH];
    logic [31:0] mEc;
    logic [31:0] ecOffset;
    int          ph;
    bit          acc;

    initial cyc = 0;

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mN[i]     = DEF_DIV;
                mPend[i]  = 1'b0;
                mPd[i]    = 0;
                mHi[i]    = 1'b0;
                mStb[i]   = 1'b0;
                mLast[i]  = 1'b0;
                mStart[i] = cyc + 1;
            end
            mEc = '0;
        end else begin
            cyc = cyc + 1;
            if (mStb[CNT_CH]) mEc = mEc + 32'd1;
            for (int i = 0; i < NUM_CH; i++) begin
                acc = cfg_valid && (int'(cfg_ch) == i) && !mPend[i];
                mHi[i]   = 1'b0;
                mStb[i]  = 1'b0;
                mLast[i] = 1'b0;
                if (sync_restart) begin
                    if (acc) mN[i] = int'(cfg_div);
                    else if (mPend[i]) mN[i] = mPd[i];
                    mPend[i]  = 1'b0;
                    mStart[i] = cyc + 1;
                end else begin
                    ph = (mN[i] < 2) ? 0 : (cyc - mStart[i]) % mN[i];
                    if (ph == 0 && mPend[i]) begin
                        mN[i]     = mPd[i];
                        mPend[i]  = 1'b0;
                        mStart[i] = cyc;
                    end
                    if (mN[i] >= 2) begin
                        ph       = (cyc - mStart[i]) % mN[i];
                        mHi[i]   = ph < (mN[i] + 1) / 2;
                        mStb[i]  = (ph == 0);
                        mLast[i] = (mN[i] % 2 == 1) && (ph == (mN[i] + 1) / 2 - 1);
                    end
                    if (acc) begin
                        mPend[i] = 1'b1;
                        mPd[i]   = int'(cfg_div);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic compareModel();
        logic [NUM_CH-1:0] eHi;
        logic [NUM_CH-1:0] eStb;
        for (int i = 0; i < NUM_CH; i++) begin
            eHi[i]  = mHi[i];
            eStb[i] = mStb[i];
        end
        checkOutput("model clk_div", 32'(clk_div), 32'(eHi));
        checkOutput("model div_stb", 32'(div_stb), 32'(eStb));
        checkOutput("model edge_count", edge_count, mEc + ecOffset);
        checkOutput("model cfg_ready", 32'(cfg_ready), 32'(!mPend[cfg_ch]));
    endtask

`ifdef CLKDIV_ODD50_EN
    task automatic compareNeg();
        logic [NUM_CH-1:0] eHi;
        for (int i = 0; i < NUM_CH; i++) begin
            eHi[i] = mHi[i] && !(mLast[i] && mN[i] >= 3);
        end
        checkOutput("model clk_div mid-cycle", 32'(clk_div), 32'(eHi));
    endtask
`endif

    // Advance one clk_in cycle and compare against the model just after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (!rst) compareModel();
`ifdef CLKDIV_ODD50_EN
        @(negedge clk_in);
        #1;
        if (!rst) compareNeg();
`endif
    endtask

    // Present a config request (optionally with restart) and hold it until accepted.
    task automatic applyStimulus(input logic [1:0] ch, input logic [DIV_W-1:0] div, input logic rs);
        int budget;
        budget       = 64;
        cfg_valid    = 1'b1;
        cfg_ch       = ch;
        cfg_div      = div;
        sync_restart = rs;
        #1;
        while (!cfg_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) checkOutput("cfg accept timeout", 32'd0, 32'd1);
        tick();
        cfg_valid    = 1'b0;
        sync_restart = 1'b0;
    endtask

    // Wait until the addressed channel's pending divisor has been applied.
    task automatic waitReady(input logic [1:0] ch);
        int budget;
        budget = 64;
        cfg_ch = ch;
        #1;
        while (!cfg_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) checkOutput("apply timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired, %0d/%0d checks passed", passes, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] pat;
        int pulses;
        checks       = 0;
        passes       = 0;
        ecOffset     = '0;
        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_div      = '0;
        sync_restart = 1'b0;

        // Reset state.
        repeat (3) tick();
        checkOutput("reset clk_div", 32'(clk_div), 32'd0);
        checkOutput("reset div_stb", 32'(div_stb), 32'd0);
        checkOutput("reset edge_count", edge_count, 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);

        // Default N=2 after release: every channel high with a strobe on the first edge.
        @(negedge clk_in);
        rst = 1'b0;
        tick();
        checkOutput("first edge clk_div", 32'(clk_div), 32'hF);
        checkOutput("first edge div_stb", 32'(div_stb), 32'hF);
        repeat (9) tick();
        checkOutput("edge_count after 10", edge_count, 32'd5);
        checkOutput("edge 10 clk_div low", 32'(clk_div), 32'd0);

        // ch0 -> N=4 accepted mid-period; ready low until the boundary.
        applyStimulus(2'd0, 8'd4, 1'b0);
        checkOutput("ch0 ready low", 32'(cfg_ready), 32'd0);
        tick();
        checkOutput("ch0 old low phase", 32'(clk_div[0]), 32'd0);
        pat = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pat[k] = clk_div[0];
            if (k == 0) checkOutput("ch0 new period stb", 32'(div_stb[0]), 32'd1);
        end
        checkOutput("ch0 N=4 pattern", 32'(pat[3:0]), 32'b0011);

        // ch1 -> N=5: three high, two low at the clock edges.
        applyStimulus(2'd1, 8'd5, 1'b0);
        waitReady(2'd1);
        pat = '0;
        pat[0] = clk_div[1];
        for (int k = 1; k < 5; k++) begin
            tick();
            pat[k] = clk_div[1];
        end
        checkOutput("ch1 N=5 pattern", 32'(pat[4:0]), 32'b00111);

        // ch2 -> N=1 disables it, then N=6 starts on the very next edge.
        applyStimulus(2'd2, 8'd1, 1'b0);
        waitReady(2'd2);
        pat = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pat[0] = pat[0] | clk_div[2] | div_stb[2];
        end
        checkOutput("ch2 disabled", 32'(pat[0]), 32'd0);
        applyStimulus(2'd2, 8'd6, 1'b0);
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            pat[k] = clk_div[2];
        end
        checkOutput("ch2 N=6 pattern", 32'(pat[5:0]), 32'b000111);

        // N=3,4,7 on ch1..3, then restart together with ch0 -> N=8.
        applyStimulus(2'd1, 8'd3, 1'b0);
        waitReady(2'd1);
        applyStimulus(2'd2, 8'd4, 1'b0);
        waitReady(2'd2);
        applyStimulus(2'd3, 8'd7, 1'b0);
        waitReady(2'd3);
        applyStimulus(2'd0, 8'd8, 1'b1);
        tick();
        checkOutput("restart clk_div", 32'(clk_div), 32'hF);
        checkOutput("restart div_stb", 32'(div_stb), 32'hF);
        repeat (3) tick();
        checkOutput("restart +3 clk_div", 32'(clk_div), 32'b1011);
        tick();
        checkOutput("restart +4 clk_div", 32'(clk_div), 32'b0110);

        // Edge counter wrap on ch0 at N=2.
        applyStimulus(2'd0, 8'd2, 1'b0);
        waitReady(2'd0);
        if (div_stb[0]) tick();
        ecOffset = 32'hFFFF_FFFE - mEc;
        force dut.r_edge_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_edge_count;
        pulses = 0;
        for (int k = 0; k < 10 && pulses < 2; k++) begin
            tick();
            if (div_stb[0]) pulses++;
        end
        tick();
        checkOutput("edge_count wrap", edge_count, 32'd0);

        // Asynchronous reset while ch0 is high.
        pulses = 0;
        while (!clk_div[0] && pulses < 10) begin
            tick();
            pulses++;
        end
        checkOutput("ch0 high before reset", 32'(clk_div[0]), 32'd1);
        #1;
        rst = 1'b1;
        ecOffset = '0;
        #1;
        checkOutput("async reset clk_div", 32'(clk_div), 32'd0);
        checkOutput("async reset div_stb", 32'(div_stb), 32'd0);
        checkOutput("async reset edge_count", edge_count, 32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
